// File: rtl/bit_stream_pkg.sv
// Shared types and default sizing for the bit-stream sequencer.
package bit_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } bss_state_t;

  localparam int unsigned BSS_WIDTH = 12;
  localparam int unsigned BSS_POS_W = $clog2(BSS_WIDTH);
  localparam int unsigned BSS_CNT_W = $clog2(BSS_WIDTH + 1);

endpackage

// File: rtl/bit_stream_sequencer_piso_shift.sv
// Loadable MSB-first parallel-in/serial-out shift register.
module piso_shift #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= {sr[WIDTH-2:0], 1'b0};
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/bit_stream_sequencer.sv
// Word-to-bit scheduler for a serial 1001 detector: clears it, shifts a word
// in MSB-first and reports the detection count and first match position.
module bit_stream_sequencer
  import bit_stream_pkg::*;
#(
  parameter int unsigned WIDTH      = BSS_WIDTH,
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned LOCK_LAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       det_rst_n,
  output logic                       det_din,
  input  logic                       det_lock,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_hit,
  output logic [$clog2(WIDTH)-1:0]   out_first_pos,
  output logic [$clog2(WIDTH+1)-1:0] out_count
);

  localparam int unsigned POS_W = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned IDX_W = $clog2(WIDTH + LOCK_LAT + 1);
  localparam int unsigned CLR_W = $clog2(CLR_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH + LOCK_LAT - 1);
  localparam logic [IDX_W-1:0] LAT_IDX  = IDX_W'(LOCK_LAT);
  localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

  bss_state_t       state;
  logic [CLR_W-1:0] clr_cnt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] lock_pos;
  logic             sr_load;
  logic             sr_shift;
  logic             sr_msb;
  logic             in_window;
  logic             lock_sample;

  assign sr_load  = (state == IDLE) && in_valid && in_ready;
  // det_din is registered, so the register advances on the edge that
  // presents a bit, including the CLEAR->SHIFT edge carrying the MSB.
  assign sr_shift = ((state == CLEAR) && (clr_cnt == CLR_LAST)) ||
                    ((state == SHIFT) && (idx != LAST_BIT));

  piso_shift #(
    .WIDTH(WIDTH)
  ) u_piso (
    .clk  (clk),
    .rst  (rst),
    .load (sr_load),
    .shift(sr_shift),
    .din  (in_data),
    .msb  (sr_msb)
  );

  if (LOCK_LAT == 0) begin : g_no_lat
    assign in_window = 1'b1;
  end else begin : g_lat
    assign in_window = (idx >= LAT_IDX);
  end

  assign lock_pos    = idx - LAT_IDX;
  assign lock_sample = det_lock &&
                       (((state == SHIFT) && in_window) || (state == DRAIN));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      clr_cnt       <= '0;
      idx           <= '0;
      in_ready      <= 1'b1;
      det_rst_n     <= 1'b0;
      det_din       <= 1'b0;
      out_valid     <= 1'b0;
      out_hit       <= 1'b0;
      out_first_pos <= '0;
      out_count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          det_rst_n <= 1'b1;
          if (in_valid && in_ready) begin
            state         <= CLEAR;
            in_ready      <= 1'b0;
            det_rst_n     <= 1'b0;
            clr_cnt       <= '0;
            idx           <= '0;
            out_hit       <= 1'b0;
            out_first_pos <= '0;
            out_count     <= '0;
          end
        end
        CLEAR: begin
          if (clr_cnt == CLR_LAST) begin
            state     <= SHIFT;
            det_rst_n <= 1'b1;
            det_din   <= sr_msb;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        SHIFT: begin
          idx <= idx + 1'b1;
          if (idx == LAST_BIT) begin
            det_din <= 1'b0;
            if (LOCK_LAT == 0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state <= DRAIN;
            end
          end else begin
            det_din <= sr_msb;
          end
        end
        DRAIN: begin
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      if (lock_sample) begin
        out_count <= out_count + CNT_W'(1);
        if (!out_hit) begin
          out_hit       <= 1'b1;
          out_first_pos <= POS_W'(lock_pos);
        end
      end
    end
  end

endmodule

// File: tb/tb_bit_stream_sequencer.sv
// Randomized self-checking bench: three sequencers (LOCK_LAT 1, 0, 2), each
// driving a behavioural 1001 detector, checked against a word-level model.
module tb_bit_stream_sequencer;

  localparam int unsigned W    = 12;
  localparam int unsigned CLR  = 2;
  localparam int unsigned NDUT = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid      [NDUT];
  logic           in_ready      [NDUT];
  logic [W-1:0]   in_data       [NDUT];
  logic           det_rst_n     [NDUT];
  logic           det_din       [NDUT];
  logic           det_lock      [NDUT];
  logic           out_valid     [NDUT];
  logic           out_ready     [NDUT];
  logic           out_hit       [NDUT];
  logic [3:0]     out_first_pos [NDUT];
  logic [3:0]     out_count     [NDUT];

  logic           noise         [NDUT];
  logic           match_now     [NDUT];
  logic [2:0]     hist          [NDUT];
  logic [2:0]     mpipe         [NDUT];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  function automatic int unsigned lat_of(input int unsigned i);
    case (i)
      0:       return 1;
      1:       return 0;
      default: return 2;
    endcase
  endfunction

  bit_stream_sequencer #(.WIDTH(W), .CLR_CYCLES(CLR), .LOCK_LAT(1)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .det_rst_n(det_rst_n[0]), .det_din(det_din[0]),
    .det_lock(det_lock[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_hit(out_hit[0]), .out_first_pos(out_first_pos[0]), .out_count(out_count[0])
  );

  bit_stream_sequencer #(.WIDTH(W), .CLR_CYCLES(CLR), .LOCK_LAT(0)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .det_rst_n(det_rst_n[1]), .det_din(det_din[1]),
    .det_lock(det_lock[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_hit(out_hit[1]), .out_first_pos(out_first_pos[1]), .out_count(out_count[1])
  );

  bit_stream_sequencer #(.WIDTH(W), .CLR_CYCLES(CLR), .LOCK_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_data(in_data[2]), .det_rst_n(det_rst_n[2]), .det_din(det_din[2]),
    .det_lock(det_lock[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_hit(out_hit[2]), .out_first_pos(out_first_pos[2]), .out_count(out_count[2])
  );

  // Behavioural detector: flags the cycle whose bit completes 1001, delayed
  // by the latency; spurious locks are injected while it is cleared or idle.
  always_comb begin
    for (int i = 0; i < NDUT; i++) begin
      match_now[i] = det_rst_n[i] && ({hist[i], det_din[i]} == 4'b1001);
      if (lat_of(i) == 0) det_lock[i] = match_now[i];
      else                det_lock[i] = mpipe[i][lat_of(i)-1];
      det_lock[i] = det_lock[i] | (noise[i] & (!det_rst_n[i] | in_ready[i]));
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      if (!det_rst_n[i]) begin
        hist[i]  <= '0;
        mpipe[i] <= '0;
      end else begin
        hist[i]  <= {hist[i][1:0], det_din[i]};
        mpipe[i] <= {mpipe[i][1:0], match_now[i]};
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) noise[i] = 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level reference: every position p whose last four sent bits are 1001.
  function automatic void ref_model(input logic [W-1:0] w, output int unsigned hit,
                                    output int unsigned pos, output int unsigned cnt);
    logic [W-1:0] b;
    hit = 0; pos = 0; cnt = 0;
    for (int j = 0; j < W; j++) b[j] = w[W-1-j];
    for (int p = 3; p < W; p++) begin
      if (b[p-3] && !b[p-2] && !b[p-1] && b[p]) begin
        cnt++;
        if (hit == 0) begin
          hit = 1;
          pos = p;
        end
      end
    end
  endfunction

  function automatic logic [W-1:0] planted(input int unsigned p);
    logic [W-1:0] w;
    w = '0;
    w[W-1-(p-3)] = 1'b1;
    w[W-1-p]     = 1'b1;
    return w;
  endfunction

  task automatic check_reset_values(input int i);
    check("rst_in_ready",  in_ready[i], 1);
    check("rst_det_rst_n", det_rst_n[i], 0);
    check("rst_det_din",   det_din[i], 0);
    check("rst_out_valid", out_valid[i], 0);
    check("rst_out_hit",   out_hit[i], 0);
    check("rst_first_pos", out_first_pos[i], 0);
    check("rst_count",     out_count[i], 0);
  endtask

  // Called just after a negedge. Offers w, waits for the result, optionally
  // stalls out_ready and offers the next word during the stall.
  task automatic run_word(input int i, input logic [W-1:0] w, input int stall,
                          input bit offer, input logic [W-1:0] nxt);
    int unsigned eh, ep, ec, cyc, guard;
    ref_model(w, eh, ep, ec);
    in_valid[i] = 1'b1;
    in_data[i]  = w;
    guard = 0;
    while (!in_ready[i] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("accept_wait", (guard < 50) ? 1 : 0, 1);
    @(negedge clk);
    in_valid[i] = 1'b0;
    check("busy_in_ready", in_ready[i], 0);
    check("clear_rst_n", det_rst_n[i], 0);
    cyc = 1;
    while (!out_valid[i] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("latency", cyc, 1 + CLR + W + lat_of(i));
    check("done_in_ready", in_ready[i], 0);
    check("hit", out_hit[i], eh);
    check("first_pos", out_first_pos[i], ep);
    check("count", out_count[i], ec);
    if (offer) begin
      in_valid[i] = 1'b1;
      in_data[i]  = nxt;
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", out_valid[i], 1);
      check("stall_in_ready", in_ready[i], 0);
      check("stall_result", {out_hit[i], out_first_pos[i], out_count[i]},
            {eh[0], ep[3:0], ec[3:0]});
    end
    out_ready[i] = 1'b1;
    @(negedge clk);
    out_ready[i] = 1'b0;
    check("post_valid", out_valid[i], 0);
    check("post_in_ready", in_ready[i], 1);
  endtask

  task automatic reset_mid_word();
    int unsigned seen;
    in_valid[0] = 1'b1;
    in_data[0]  = 12'b100100110011;
    while (!in_ready[0]) @(negedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_values(0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_det_rst_n", det_rst_n[0], 1);
    seen = 0;
    for (int c = 0; c < 25; c++) begin
      if (out_valid[0]) seen++;
      @(negedge clk);
    end
    check("rst_no_valid", seen, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    int unsigned  i, p;
    rst = 1'b1;
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b0;
      noise[k]     = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NDUT; k++) check_reset_values(k);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) check("idle_det_rst_n", det_rst_n[k], 1);

    run_word(0, 12'b100100110011, 0, 1'b0, '0);
    run_word(0, 12'b000000000000, 1, 1'b0, '0);
    run_word(0, 12'b100110011001, 2, 1'b0, '0);
    run_word(0, 12'b111111111111, 0, 1'b0, '0);
    run_word(0, 12'b100100110011, 20, 1'b1, 12'b100110011001);
    run_word(0, 12'b100110011001, 0, 1'b0, '0);

    reset_mid_word();
    run_word(0, 12'b100100110011, 0, 1'b0, '0);

    run_word(1, planted(5), 0, 1'b0, '0);
    run_word(1, planted(3), 1, 1'b0, '0);
    run_word(2, planted(11), 0, 1'b0, '0);
    run_word(2, planted(7), 2, 1'b0, '0);

    for (int n = 0; n < 36; n++) begin
      i = n % NDUT;
      if ($urandom_range(0, 1) == 1) begin
        p = $urandom_range(3, W - 1);
        w = planted(p);
      end else begin
        w = W'($urandom);
      end
      run_word(int'(i), w, int'($urandom_range(0, 3)), 1'b0, '0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
